// File: rtl/ecc_scalar_bit_sequencer.sv
// Double-and-add sequencer for ECC scalar multiply: walks scalar bits MSB->LSB via an external
// down counter and issues DBL/ADD/INIT commands. Define LEADING_ZERO_SKIP_EN to skip leading zeros.
module ecc_scalar_bit_sequencer #(
    parameter int unsigned KEY_W = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] scalar,
    input  logic [IDX_W-1:0] bit_idx,
    output logic             cnt_step,
    output logic             op_valid,
    output logic [1:0]       op_code,
    input  logic             op_ready,
    input  logic             op_done,
    output logic             busy,
    output logic             done,
    output logic             result_inf
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ALIGN  = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_DBL    = 4'd3;
    localparam logic [3:0] S_WAIT_D = 4'd4;
    localparam logic [3:0] S_ADD    = 4'd5;
    localparam logic [3:0] S_WAIT_A = 4'd6;
    localparam logic [3:0] S_STEP   = 4'd7;
    localparam logic [3:0] S_FIN    = 4'd8;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_DBL  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_INIT = 2'b11;

    // KEY_W == 2**IDX_W, so the top bit index is the all-ones index
    localparam logic [IDX_W-1:0] IDX_TOP = '1;

    logic [3:0]       state;
    logic [3:0]       state_d;
    logic [KEY_W-1:0] scalar_q;
    logic             bit_q;
    logic             init_q;
    logic             bit_cur;
    logic             q_def;

`ifndef LEADING_ZERO_SKIP_EN
    assign q_def = 1'b1;
`endif

    assign bit_cur = scalar_q[bit_idx];

    always_comb begin
        state_d  = state;
        cnt_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (bit_idx != IDX_TOP) cnt_step = 1'b1;
                else                    state_d  = S_FETCH;
            end
            S_FETCH: begin
`ifdef LEADING_ZERO_SKIP_EN
                if (!q_def && !bit_cur) state_d = S_STEP;
                else if (!q_def)        state_d = S_ADD;
                else                    state_d = S_DBL;
`else
                state_d = S_DBL;
`endif
            end
            S_DBL: begin
                if (op_ready) state_d = S_WAIT_D;
            end
            S_WAIT_D: begin
                if (op_done) state_d = bit_q ? S_ADD : S_STEP;
            end
            S_ADD: begin
                if (op_ready) state_d = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (op_done) state_d = S_STEP;
            end
            S_STEP: begin
                if (bit_idx == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        op_valid = (state == S_DBL) || (state == S_ADD);
        op_code  = OP_NONE;
        if (state == S_DBL)      op_code = OP_DBL;
        else if (state == S_ADD) op_code = init_q ? OP_INIT : OP_ADD;
        busy = (state != S_IDLE) && (state != S_FIN);
        done = (state == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            scalar_q   <= '0;
            bit_q      <= 1'b0;
            init_q     <= 1'b0;
            result_inf <= 1'b0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && start) begin
                scalar_q   <= scalar;
                result_inf <= 1'b0;
            end
            if (state == S_FETCH) begin
                bit_q  <= bit_cur;
                init_q <= !q_def && bit_cur;
            end
            if (state == S_STEP && bit_idx == '0) result_inf <= (scalar_q == '0);
        end
    end

`ifdef LEADING_ZERO_SKIP_EN
    // Q becomes defined by the first INIT; until then zero bits are stepped over silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_def <= 1'b0;
        end else begin
            if (state == S_IDLE && start)        q_def <= 1'b0;
            else if (state == S_FETCH && bit_cur) q_def <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_scalar_bit_sequencer.sv
// Directed bench for ecc_scalar_bit_sequencer with a behavioural mod-256 down counter and an
// arithmetic-unit stub (programmable ready delay and done latency); honours LEADING_ZERO_SKIP_EN.
`timescale 1ns/1ps
module tb_ecc_scalar_bit_sequencer;

    localparam int KEY_W = 256;
    localparam int IDX_W = 8;
    localparam logic [1:0] C_DBL  = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_INIT = 2'b11;
`ifdef LEADING_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [KEY_W-1:0] scalar;
    logic [IDX_W-1:0] cnt;
    logic             cnt_step;
    logic             op_valid;
    logic [1:0]       op_code;
    logic             op_ready;
    logic             op_done;
    logic             busy;
    logic             done;
    logic             result_inf;

    logic             cnt_load = 1'b0;
    logic [IDX_W-1:0] cnt_load_val = '0;

    int vectors = 0;
    int miscompares = 0;

    int   latency = 2;
    int   rdelay = 0;
    bit   spur_done = 1'b0;
    int   vcnt = 0;
    bit   pend = 1'b0;
    int   lat_cnt = 0;
    bit   prev_v = 1'b0;
    logic [1:0] prev_code = '0;
    logic [7:0] prev_idx = '0;
    logic [9:0] log_q[$];
    int   step_cnt = 0;
    int   stable_err = 0;

    ecc_scalar_bit_sequencer #(.KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .scalar     (scalar),
        .bit_idx    (cnt),
        .cnt_step   (cnt_step),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_ready   (op_ready),
        .op_done    (op_done),
        .busy       (busy),
        .done       (done),
        .result_inf (result_inf)
    );

    always #5 clk = ~clk;

    // Counter has no reset; bench preloads it
    always @(posedge clk) begin
        if (cnt_load)      cnt <= cnt_load_val;
        else if (cnt_step) cnt <= cnt - 8'd1;
    end

    // Arithmetic stub: logs each accepted command, pulses op_done `latency` cycles later
    always @(negedge clk) begin
        if (!rst_n) begin
            op_ready = 1'b0;
            vcnt     = 0;
            prev_v   = 1'b0;
        end else begin
            if (prev_v && op_ready) begin
                log_q.push_back({prev_code, prev_idx});
                pend    = 1'b1;
                lat_cnt = latency;
                vcnt    = 0;
            end else if (prev_v) begin
                if (!op_valid || op_code !== prev_code || cnt !== prev_idx) stable_err++;
            end
            if (op_valid) begin
                op_ready = (vcnt >= rdelay);
                vcnt++;
            end else begin
                op_ready = (rdelay == 0);
            end
            prev_v    = op_valid;
            prev_code = op_code;
            prev_idx  = cnt;
        end
        op_done = 1'b0;
        if (pend) begin
            if (lat_cnt <= 1) begin
                op_done = 1'b1;
                pend    = 1'b0;
            end else begin
                lat_cnt--;
            end
        end
        if (spur_done && op_valid) op_done = 1'b1;
        if (cnt_step) step_cnt++;
    end

    // Reference double-and-add walk; returns first differing log position or -1
    function automatic int seq_mismatch(input logic [KEY_W-1:0] k);
        logic [9:0] exp_q[$];
        bit q_d;
        int n;
        q_d = !SKIP;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (!q_d) begin
                if (k[i]) begin
                    exp_q.push_back({C_INIT, 8'(i)});
                    q_d = 1'b1;
                end
            end else begin
                exp_q.push_back({C_DBL, 8'(i)});
                if (k[i]) exp_q.push_back({C_ADD, 8'(i)});
            end
        end
        n = (exp_q.size() < log_q.size()) ? exp_q.size() : log_q.size();
        for (int j = 0; j < n; j++) if (exp_q[j] !== log_q[j]) return j;
        if (exp_q.size() != log_q.size()) return n;
        return -1;
    endfunction

    function automatic int n_code(input logic [1:0] c);
        int n = 0;
        foreach (log_q[j]) if (log_q[j][9:8] == c) n++;
        return n;
    endfunction

    task automatic run_op(input logic [KEY_W-1:0] k, input bit load, input logic [7:0] cnt_init,
                          input bit spur_start, output int done_pulses, output bit timeout,
                          output bit saw_busy);
        int cyc;
        @(negedge clk); #1;
        log_q.delete();
        step_cnt = 0;
        stable_err = 0;
        done_pulses = 0;
        timeout = 1'b0;
        saw_busy = 1'b0;
        if (load) begin
            cnt_load_val = cnt_init;
            cnt_load = 1'b1;
            @(negedge clk); #1;
            cnt_load = 1'b0;
        end
        scalar = k;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        scalar = '0;
        cyc = 0;
        while (done_pulses == 0 && cyc < 20000) begin
            if (busy) saw_busy = 1'b1;
            if (done) done_pulses++;
            start = spur_start && busy && (cyc % 7 == 3);
            @(negedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (done_pulses == 0) timeout = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done) done_pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        scalar = '0;
        cnt_load_val = 8'h37;
        cnt_load = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        cnt_load = 1'b0;
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (op_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
        vectors++; if (op_code !== 2'b00)   begin miscompares++; $display("FAIL reset_op_code: got %b want 00", op_code); end
        vectors++; if (cnt_step !== 1'b0)   begin miscompares++; $display("FAIL reset_cnt_step: got %b want 0", cnt_step); end
        vectors++; if (result_inf !== 1'b0) begin miscompares++; $display("FAIL reset_result_inf: got %b want 0", result_inf); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_bit();
        int dp; bit to; bit sb; int mm;
        latency = 2; rdelay = 0;
        run_op(256'd1, 1'b1, 8'h37, 1'b0, dp, to, sb);
        mm = seq_mismatch(256'd1);
        vectors++; if (to !== 1'b0)  begin miscompares++; $display("FAIL k1_timeout: no done pulse"); end
        vectors++; if (dp != 1)      begin miscompares++; $display("FAIL k1_done_pulses: got %0d want 1", dp); end
        vectors++; if (sb !== 1'b1)  begin miscompares++; $display("FAIL k1_busy_seen: got %b want 1", sb); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL k1_busy_end: got %b want 0", busy); end
        vectors++; if (result_inf !== 1'b0) begin miscompares++; $display("FAIL k1_result_inf: got %b want 0", result_inf); end
        vectors++; if (n_code(C_DBL) != (SKIP ? 0 : 256)) begin miscompares++; $display("FAIL k1_dbl_count: got %0d want %0d", n_code(C_DBL), SKIP ? 0 : 256); end
        vectors++; if (n_code(C_ADD) != (SKIP ? 0 : 1)) begin miscompares++; $display("FAIL k1_add_count: got %0d want %0d", n_code(C_ADD), SKIP ? 0 : 1); end
        vectors++; if (n_code(C_INIT) != (SKIP ? 1 : 0)) begin miscompares++; $display("FAIL k1_init_count: got %0d want %0d", n_code(C_INIT), SKIP ? 1 : 0); end
        vectors++; if (mm != -1) begin miscompares++; $display("FAIL k1_sequence: first difference at entry %0d", mm); end
        vectors++; if (step_cnt != 56 + 255) begin miscompares++; $display("FAIL k1_step_count: got %0d want 311", step_cnt); end
        vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL k1_final_idx: got %0d want 0", cnt); end
    endtask

    task automatic test_all_ones();
        int dp; bit to; bit sb; int mm;
        latency = 3; rdelay = 0;
        run_op('1, 1'b0, 8'h00, 1'b0, dp, to, sb);
        mm = seq_mismatch('1);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL ones_timeout: no done pulse"); end
        vectors++; if (dp != 1)     begin miscompares++; $display("FAIL ones_done_pulses: got %0d want 1", dp); end
        vectors++; if (sb !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL ones_busy: seen %b end %b want 1/0", sb, busy); end
        vectors++; if (n_code(C_DBL) != (SKIP ? 255 : 256)) begin miscompares++; $display("FAIL ones_dbl_count: got %0d want %0d", n_code(C_DBL), SKIP ? 255 : 256); end
        vectors++; if (n_code(C_ADD) != (SKIP ? 255 : 256)) begin miscompares++; $display("FAIL ones_add_count: got %0d want %0d", n_code(C_ADD), SKIP ? 255 : 256); end
        vectors++; if (mm != -1) begin miscompares++; $display("FAIL ones_sequence: first difference at entry %0d", mm); end
        vectors++; if (step_cnt != 1 + 255) begin miscompares++; $display("FAIL ones_step_count: got %0d want 256", step_cnt); end
        vectors++; if (result_inf !== 1'b0) begin miscompares++; $display("FAIL ones_result_inf: got %b want 0", result_inf); end
    endtask

    task automatic test_zero();
        int dp; bit to; bit sb;
        latency = 2; rdelay = 0;
        run_op('0, 1'b0, 8'h00, 1'b0, dp, to, sb);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL zero_timeout: no done pulse"); end
        vectors++; if (dp != 1)     begin miscompares++; $display("FAIL zero_done_pulses: got %0d want 1", dp); end
        vectors++; if (log_q.size() != (SKIP ? 0 : 256)) begin miscompares++; $display("FAIL zero_cmd_count: got %0d want %0d", log_q.size(), SKIP ? 0 : 256); end
        vectors++; if (n_code(C_DBL) != (SKIP ? 0 : 256)) begin miscompares++; $display("FAIL zero_dbl_count: got %0d want %0d", n_code(C_DBL), SKIP ? 0 : 256); end
        vectors++; if (result_inf !== 1'b1) begin miscompares++; $display("FAIL zero_result_inf: got %b want 1", result_inf); end
        vectors++; if (step_cnt != 256) begin miscompares++; $display("FAIL zero_step_count: got %0d want 256", step_cnt); end
    endtask

    task automatic test_stall();
        int dp; bit to; bit sb; int mm;
        logic [KEY_W-1:0] k;
        k = '0; k[255] = 1'b1; k[2] = 1'b1; k[0] = 1'b1;
        latency = 1; rdelay = 5;
        run_op(k, 1'b1, 8'hFF, 1'b0, dp, to, sb);
        mm = seq_mismatch(k);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL stall_timeout: no done pulse"); end
        vectors++; if (stable_err != 0) begin miscompares++; $display("FAIL stall_hold: %0d unstable valid cycles, want 0", stable_err); end
        vectors++; if (mm != -1) begin miscompares++; $display("FAIL stall_sequence: first difference at entry %0d", mm); end
        vectors++; if (n_code(C_ADD) != (SKIP ? 2 : 3)) begin miscompares++; $display("FAIL stall_add_count: got %0d want %0d", n_code(C_ADD), SKIP ? 2 : 3); end
        vectors++; if (log_q.size() == 0 || log_q[0] !== (SKIP ? {C_INIT, 8'd255} : {C_DBL, 8'd255})) begin miscompares++; $display("FAIL stall_first_cmd: got %h want %h", (log_q.size() != 0) ? log_q[0] : 10'h0, SKIP ? {C_INIT, 8'd255} : {C_DBL, 8'd255}); end
        vectors++; if (log_q.size() == 0 || log_q[$] !== {C_ADD, 8'd0}) begin miscompares++; $display("FAIL stall_last_cmd: got %h want %h", (log_q.size() != 0) ? log_q[$] : 10'h0, {C_ADD, 8'd0}); end
        vectors++; if (step_cnt != 255) begin miscompares++; $display("FAIL stall_step_count: got %0d want 255", step_cnt); end
        vectors++; if (result_inf !== 1'b0) begin miscompares++; $display("FAIL stall_result_inf: got %b want 0", result_inf); end
        rdelay = 0;
    endtask

    task automatic test_spurious();
        int dp; bit to; bit sb; int mm;
        logic [KEY_W-1:0] k;
        k = {64'h0123_4567_89AB_CDEF, 64'h0, 64'hF0F0_0000_0000_000F, 64'h8000_0000_0000_0001};
        latency = 2; rdelay = 2; spur_done = 1'b1;
        run_op(k, 1'b0, 8'h00, 1'b1, dp, to, sb);
        spur_done = 1'b0; rdelay = 0;
        mm = seq_mismatch(k);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL spur_timeout: no done pulse"); end
        vectors++; if (dp != 1)     begin miscompares++; $display("FAIL spur_done_pulses: got %0d want 1", dp); end
        vectors++; if (mm != -1)    begin miscompares++; $display("FAIL spur_sequence: first difference at entry %0d", mm); end
        vectors++; if (stable_err != 0) begin miscompares++; $display("FAIL spur_hold: %0d unstable valid cycles, want 0", stable_err); end
    endtask

    task automatic test_reset_midop();
        int dp; bit to; bit sb; int mm; int cyc; bit found;
        logic [KEY_W-1:0] k;
        latency = 5; rdelay = 0;
        @(negedge clk); #1;
        log_q.delete();
        scalar = '1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 20000) begin
            @(negedge clk); #1;
            cyc++;
            if (log_q.size() != 0 && log_q[$] === {C_ADD, 8'd100}) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rst_reach_idx100: ADD at idx 100 not seen within %0d cycles", cyc); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({busy, done, op_valid, cnt_step} !== 4'b0000) begin miscompares++; $display("FAIL rst_async_ctrl: got busy/done/valid/step=%b want 0000", {busy, done, op_valid, cnt_step}); end
        vectors++; if (op_code !== 2'b00 || result_inf !== 1'b0) begin miscompares++; $display("FAIL rst_async_code: got code %b inf %b want 00/0", op_code, result_inf); end
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        found = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            if (busy || done || op_valid) found = 1'b1;
        end
        vectors++; if (found) begin miscompares++; $display("FAIL rst_stale_done: activity after reset with no start, want idle"); end
        k = '0; k[255] = 1'b1; k[2] = 1'b1; k[0] = 1'b1;
        latency = 2;
        run_op(k, 1'b0, 8'h00, 1'b0, dp, to, sb);
        mm = seq_mismatch(k);
        vectors++; if (to !== 1'b0 || dp != 1) begin miscompares++; $display("FAIL rst_rerun_done: timeout %b pulses %0d want 0/1", to, dp); end
        vectors++; if (mm != -1) begin miscompares++; $display("FAIL rst_rerun_sequence: first difference at entry %0d", mm); end
        vectors++; if (step_cnt != 101 + 255) begin miscompares++; $display("FAIL rst_rerun_steps: got %0d want 356", step_cnt); end
    endtask

    task automatic test_back_to_back();
        int dp; bit to; bit sb; int mm;
        logic [KEY_W-1:0] k;
        k = {128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0000};
        latency = 1; rdelay = 0;
        run_op(k, 1'b0, 8'h00, 1'b0, dp, to, sb);
        mm = seq_mismatch(k);
        vectors++; if (to !== 1'b0 || dp != 1) begin miscompares++; $display("FAIL b2b_done: timeout %b pulses %0d want 0/1", to, dp); end
        vectors++; if (mm != -1) begin miscompares++; $display("FAIL b2b_sequence: first difference at entry %0d", mm); end
        vectors++; if (n_code(C_DBL) != (SKIP ? 127 : 256)) begin miscompares++; $display("FAIL b2b_dbl_count: got %0d want %0d", n_code(C_DBL), SKIP ? 127 : 256); end
    endtask

    initial begin
        start = 1'b0;
        scalar = '0;
        test_reset();
        test_single_bit();
        test_all_ones();
        test_zero();
        test_stall();
        test_spurious();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
